// File: rtl/fifo_protocol_monitor_if.sv
// Observed FIFO control/pointer/data bundle, shared between a FIFO (or its driver) and the monitor.
// Latency: none, wires only.
// Backpressure: none; the monitor side is input-only and never loads the FIFO.
// Signals: wr_en/rd_en requests, full/empty flags, wr_ptr/rd_ptr pointers, wr_data/rd_data payload.
// Modports: master = FIFO side (drives everything), slave = monitor side (observes everything).
interface fifo_mon_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic                  rd_en;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, rd_en, full, empty, wr_ptr, rd_ptr, wr_data, rd_data
  );

  modport slave (
    input  wr_en, rd_en, full, empty, wr_ptr, rd_ptr, wr_data, rd_data
  );
endinterface

// File: rtl/fifo_protocol_monitor.sv
// Run-time checker for a single-clock FIFO: shadow occupancy, pointer/flag checks, sticky errors, first-error capture.
// Latency: an error seen on the interface reaches err_sticky_o/err_pulse_o/err_count_o one clock later.
// Backpressure: none; pure observer, never drives the FIFO.
// Ports: clk, rst (async, active-high); mon_en_i masks checks; clr_i clears sticky/count/first capture;
//        mon (fifo_mon_if.slave) observed FIFO signals; occupancy_o shadow count; err_sticky_o[6:0] per-code bits;
//        err_pulse_o one cycle per error cycle; err_count_o saturating error-cycle count; first_err_o/first_vld_o.
// Optional feature: define FIFO_MON_DATA_CHECK_EN for the shadow data memory and read-data check (code 6).
module fifo_protocol_monitor #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mon_en_i,
  input  logic                 clr_i,
  fifo_mon_if.slave            mon,
  output logic [ADDR_WIDTH:0]  occupancy_o,
  output logic [6:0]           err_sticky_o,
  output logic                 err_pulse_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [2:0]           first_err_o,
  output logic                 first_vld_o
);
  localparam int                DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_FAULT} state_e;
  state_e state_q, state_d;
  logic   chk_active;

  logic                  acc_w, acc_r;
  logic [ADDR_WIDTH:0]   occupancy_q, occupancy_d;
  logic                  p_wr_en_q, p_rd_en_q, p_full_q, p_empty_q, p_acc_w_q, p_acc_r_q;
  logic [ADDR_WIDTH-1:0] p_wr_ptr_q, p_rd_ptr_q, wr_ptr_inc, rd_ptr_inc;
  logic                  data_err;
  logic [6:0]            err_det, err_new;
  logic                  any_new;
  logic [2:0]            low_code;

  logic [6:0]            sticky_q, sticky_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [2:0]            first_q, first_d;
  logic                  fvld_q, fvld_d;

  assign acc_w = mon.wr_en & ~mon.full;
  assign acc_r = mon.rd_en & ~mon.empty;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_DISARMED;
    else     state_q <= state_d;
  end

  // FSM: next state. DISARMED lasts one cycle so the previous-cycle registers hold real history.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISARMED: state_d = S_ARMED;
      S_ARMED:    if (any_new) state_d = S_FAULT;
      S_FAULT:    if (clr_i && !any_new) state_d = S_ARMED;
      default:    state_d = S_DISARMED;
    endcase
  end

  // FSM: outputs
  always_comb begin
    chk_active = (state_q != S_DISARMED);
  end

  // Shadow occupancy; simultaneous accepted write and read leave it unchanged.
  always_comb begin
    occupancy_d = occupancy_q;
    if (acc_w && !acc_r && occupancy_q != DEPTH)   occupancy_d = occupancy_q + 1'b1;
    else if (acc_r && !acc_w && occupancy_q != '0) occupancy_d = occupancy_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy_q <= '0;
      p_wr_en_q   <= 1'b0;
      p_rd_en_q   <= 1'b0;
      p_full_q    <= 1'b0;
      p_empty_q   <= 1'b0;
      p_acc_w_q   <= 1'b0;
      p_acc_r_q   <= 1'b0;
      p_wr_ptr_q  <= '0;
      p_rd_ptr_q  <= '0;
    end else begin
      occupancy_q <= occupancy_d;
      p_wr_en_q   <= mon.wr_en;
      p_rd_en_q   <= mon.rd_en;
      p_full_q    <= mon.full;
      p_empty_q   <= mon.empty;
      p_acc_w_q   <= acc_w;
      p_acc_r_q   <= acc_r;
      p_wr_ptr_q  <= mon.wr_ptr;
      p_rd_ptr_q  <= mon.rd_ptr;
    end
  end

  // Pointer increment wraps naturally at DEPTH.
  assign wr_ptr_inc = p_wr_ptr_q + 1'b1;
  assign rd_ptr_inc = p_rd_ptr_q + 1'b1;

`ifdef FIFO_MON_DATA_CHECK_EN
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH_N];

  always_ff @(posedge clk) begin
    if (acc_w) shadow_q[mon.wr_ptr] <= mon.wr_data;
  end

  // Read data arrives the cycle after the accepted read, addressed by that cycle's rd_ptr.
  assign data_err = p_acc_r_q & (mon.rd_data != shadow_q[p_rd_ptr_q]);
`else
  logic [DATA_WIDTH-1:0] unused_data;
  assign unused_data = mon.wr_data ^ mon.rd_data;
  assign data_err    = 1'b0;
`endif

  always_comb begin
    err_det    = '0;
    err_det[0] = p_wr_en_q & p_full_q & (mon.wr_ptr != p_wr_ptr_q);
    err_det[1] = p_rd_en_q & p_empty_q & (mon.rd_ptr != p_rd_ptr_q);
    // A non-accepted request with movement is covered by codes 0/1; only request-less motion lands here.
    err_det[2] = p_acc_w_q ? (mon.wr_ptr != wr_ptr_inc) : (~p_wr_en_q & (mon.wr_ptr != p_wr_ptr_q));
    err_det[3] = p_acc_r_q ? (mon.rd_ptr != rd_ptr_inc) : (~p_rd_en_q & (mon.rd_ptr != p_rd_ptr_q));
    err_det[4] = mon.full  != (occupancy_q == DEPTH);
    err_det[5] = mon.empty != (occupancy_q == '0);
    err_det[6] = data_err;
  end

  assign err_new = (chk_active && mon_en_i) ? err_det : 7'd0;
  assign any_new = |err_new;

  always_comb begin
    low_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (err_new[i]) low_code = i[2:0];
    end
  end

  // clr and a new error in the same cycle: the new error is kept as if clr came first.
  always_comb begin
    sticky_d = sticky_q | err_new;
    pulse_d  = any_new;
    count_d  = count_q;
    first_d  = first_q;
    fvld_d   = fvld_q;
    if (clr_i) begin
      sticky_d = err_new;
      count_d  = any_new ? CNT_WIDTH'(1) : '0;
      first_d  = any_new ? low_code : 3'd0;
      fvld_d   = any_new;
    end else begin
      if (any_new && count_q != '1) count_d = count_q + 1'b1;
      if (any_new && !fvld_q) begin
        first_d = low_code;
        fvld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
      first_q  <= '0;
      fvld_q   <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
      first_q  <= first_d;
      fvld_q   <= fvld_d;
    end
  end

  assign occupancy_o  = occupancy_q;
  assign err_sticky_o = sticky_q;
  assign err_pulse_o  = pulse_q;
  assign err_count_o  = count_q;
  assign first_err_o  = first_q;
  assign first_vld_o  = fvld_q;
endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Bench for fifo_protocol_monitor: table of input/expected rows plus hand sequences for saturation and data check.
// Latency: expected values are queued when a row is driven and compared one clock later.
// Backpressure: none.
module tb_fifo_protocol_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mon_en, clr;
  logic [2:0] occupancy;
  logic [6:0] err_sticky;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [2:0] first_err;
  logic       first_vld;

`ifdef FIFO_MON_DATA_CHECK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  fifo_mon_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) mon_bus ();

  fifo_protocol_monitor #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mon_en_i     (mon_en),
    .clr_i        (clr),
    .mon          (mon_bus),
    .occupancy_o  (occupancy),
    .err_sticky_o (err_sticky),
    .err_pulse_o  (err_pulse),
    .err_count_o  (err_count),
    .first_err_o  (first_err),
    .first_vld_o  (first_vld)
  );

  typedef struct {
    logic       r, m, c, we, re, f, e;
    logic [1:0] wp, rp;
    logic [7:0] wd, rdd;
    logic [2:0] occ;
    logic [6:0] st;
    logic       p;
    logic [7:0] cnt;
    logic [2:0] fe;
    logic       fv;
  } vec_t;

  typedef struct {
    int         tag;
    logic [2:0] occ;
    logic [6:0] st;
    logic       p;
    logic [7:0] cnt;
    logic [2:0] fe;
    logic       fv;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic m, input logic c, input logic we,
                              input logic re, input logic f, input logic e,
                              input logic [1:0] wp, input logic [1:0] rp,
                              input logic [2:0] occ, input logic [6:0] st, input logic p,
                              input logic [7:0] cnt, input logic [2:0] fe, input logic fv);
    vec_t v;
    v.r = r; v.m = m; v.c = c; v.we = we; v.re = re; v.f = f; v.e = e;
    v.wp = wp; v.rp = rp; v.wd = 8'h00; v.rdd = 8'h00;
    v.occ = occ; v.st = st; v.p = p; v.cnt = cnt; v.fe = fe; v.fv = fv;
    return v;
  endfunction

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, t, act, exp);
    end
  endtask

  task automatic compare_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("occupancy",  e.tag, 32'(occupancy),  32'(e.occ));
      chk("err_sticky", e.tag, 32'(err_sticky), 32'(e.st));
      chk("err_pulse",  e.tag, 32'(err_pulse),  32'(e.p));
      chk("err_count",  e.tag, 32'(err_count),  32'(e.cnt));
      chk("first_err",  e.tag, 32'(first_err),  32'(e.fe));
      chk("first_vld",  e.tag, 32'(first_vld),  32'(e.fv));
    end
  endtask

  // Drive on the falling edge; the row's effect is compared at the next falling edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    compare_pending();
    rst             = v.r;
    mon_en          = v.m;
    clr             = v.c;
    mon_bus.wr_en   = v.we;
    mon_bus.rd_en   = v.re;
    mon_bus.full    = v.f;
    mon_bus.empty   = v.e;
    mon_bus.wr_ptr  = v.wp;
    mon_bus.rd_ptr  = v.rp;
    mon_bus.wr_data = v.wd;
    mon_bus.rd_data = v.rdd;
    e.tag = tag; e.occ = v.occ; e.st = v.st; e.p = v.p; e.cnt = v.cnt; e.fe = v.fe; e.fv = v.fv;
    sb.push_back(e);
    tag++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       v;
    logic [7:0] cnt_exp;

    rst = 1'b1; mon_en = 1'b0; clr = 1'b0;
    mon_bus.wr_en = 1'b0; mon_bus.rd_en = 1'b0; mon_bus.full = 1'b0; mon_bus.empty = 1'b1;
    mon_bus.wr_ptr = 2'd0; mon_bus.rd_ptr = 2'd0; mon_bus.wr_data = 8'h00; mon_bus.rd_data = 8'h00;

    //               r  m  c we re  f  e wp rp   occ st    p cnt fe fv
    // reset with junk inputs, then a DISARMED cycle with a flag lie and moved pointers
    tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 2, 3,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 3, 0,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 1,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 1,  0, 7'h20, 1, 1, 5, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 2, 1,  0, 7'h00, 0, 0, 0, 0));
    // legal traffic: 4 writes with wrap, then 4 reads
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0,  1, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0,  2, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 0,  3, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3, 0,  4, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,  4, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0,  3, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1,  2, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 2,  1, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    // fill again, then write while full with the write pointer forced forward
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0,  1, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0,  2, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 0,  3, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3, 0,  4, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0,  4, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0,  4, 7'h01, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0,  4, 7'h01, 0, 1, 0, 1));
    // reset mid-fault, 2 writes, then empty lie and full lie
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0,  1, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0,  2, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0,  2, 7'h20, 1, 1, 5, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2, 0,  2, 7'h30, 1, 2, 5, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 0,  2, 7'h30, 0, 2, 5, 1));
    // request-less motion on both pointers together with clr
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 1,  2, 7'h0C, 1, 1, 2, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // 300 consecutive error cycles: write pointer toggles with no request
    for (int i = 0; i < 300; i++) begin
      cnt_exp = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      step(mk(0, 1, 0, 0, 0, 0, 0, (i % 2 == 0) ? 2'd0 : 2'd3, 2'd1, 3'd2, 7'h0C, 1'b1, cnt_exp, 3'd2, 1'b1));
    end
    // masked checks: pointer moves without error; then a clean cycle
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 7'h0C, 0, 255, 2, 1));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  2, 7'h0C, 0, 255, 2, 1));
    // reset mid-operation
    step(mk(1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 7'h00, 0, 0, 0, 0));

    // data check: 0x11 at ptr 0, 0xA5 at ptr 1, read back 0x11 then 0x5A
    v = mk(0, 1, 0, 1, 0, 0, 1, 0, 0,  1, 7'h00, 0, 0, 0, 0); v.wd = 8'h11; step(v);
    v = mk(0, 1, 0, 1, 0, 0, 0, 1, 0,  2, 7'h00, 0, 0, 0, 0); v.wd = 8'hA5; step(v);
    v = mk(0, 1, 0, 0, 1, 0, 0, 2, 0,  1, 7'h00, 0, 0, 0, 0); step(v);
    v = mk(0, 1, 0, 0, 1, 0, 0, 2, 1,  0, 7'h00, 0, 0, 0, 0); v.rdd = 8'h11; step(v);
    v = mk(0, 1, 0, 0, 0, 0, 1, 2, 2,  0, DC ? 7'h40 : 7'h00, DC, DC ? 8'd1 : 8'd0, DC ? 3'd6 : 3'd0, DC);
    v.rdd = 8'h5A; step(v);
    v = mk(0, 1, 0, 0, 0, 0, 1, 2, 2,  0, DC ? 7'h40 : 7'h00, 0, DC ? 8'd1 : 8'd0, DC ? 3'd6 : 3'd0, DC);
    step(v);

    @(negedge clk);
    compare_pending();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
